// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS-subset control sequencer with Moore outputs
// and a req/ready memory handshake.
module mc_control_fsm #(
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic [2:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               bad_op,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [STATE_W-1:0] {
    RST = '0, FETCH, FLATCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MADDR,
    MRD, WB_MEM, MWR, BRANCH, JUMP, JAL, JR, TRAP
  } state_e;
  state_e state_q, state_d;
  logic   r_ok;
  assign r_ok  = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  assign state = state_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:    state_d = FETCH;
      FETCH:  state_d = mem_ready ? FLATCH : FETCH;
      FLATCH: state_d = DECODE;
      DECODE: case (opcode)
        6'h00:   state_d = r_ok ? EXEC_R : (funct == 6'h08) ? JR : TRAP;
        6'h08:   state_d = EXEC_I;
        6'h23,
        6'h2B:   state_d = MADDR;
        6'h04:   state_d = BRANCH;
        6'h02:   state_d = JUMP;
        6'h03:   state_d = JAL;
        default: state_d = TRAP;
      endcase
      EXEC_R: state_d = WB_R;
      EXEC_I: state_d = WB_I;
      MADDR:  state_d = (opcode == 6'h2B) ? MWR : MRD;
      MRD:    state_d = mem_ready ? WB_MEM : MRD;
      MWR:    state_d = mem_ready ? FETCH : MWR;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR: state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = RST;
    endcase
  end
  // Outputs depend on state_q alone, so no input reaches an output combinationally.
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; iord = 1'b0; ir_write = 1'b0;
    pc_write = 1'b0; pc_write_cond = 1'b0; pc_src = 2'b00;
    alu_src_a = 1'b0; alu_src_b = 2'b00; alu_op = 3'b000;
    reg_dst = 3'b000; mem_to_reg = 2'b00; reg_write = 1'b0; bad_op = 1'b0;
    case (state_q)
      FETCH:  mem_req = 1'b1;
      FLATCH: begin ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; end
      DECODE: alu_src_b = 2'b11;
      EXEC_R: begin alu_src_a = 1'b1; alu_op = 3'b010; end
      WB_R:   begin reg_dst = 3'b001; reg_write = 1'b1; end
      EXEC_I, MADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      WB_I:   reg_write = 1'b1;
      MRD:    begin mem_req = 1'b1; iord = 1'b1; end
      WB_MEM: begin mem_to_reg = 2'b01; reg_write = 1'b1; end
      MWR:    begin mem_req = 1'b1; iord = 1'b1; mem_we = 1'b1; end
      BRANCH: begin alu_src_a = 1'b1; alu_op = 3'b001; pc_write_cond = 1'b1; pc_src = 2'b01; end
      JUMP:   begin pc_write = 1'b1; pc_src = 2'b10; end
      JAL:    begin pc_write = 1'b1; pc_src = 2'b10; reg_dst = 3'b010; mem_to_reg = 2'b10; reg_write = 1'b1; end
      JR:     begin pc_write = 1'b1; pc_src = 2'b11; end
      TRAP:   bad_op = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: builds each instruction's expected state trace from its
// class and planned wait states, then checks state and outputs every cycle.
module tb_mc_control_fsm;
  logic       clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, alu_src_a, reg_write, bad_op;
  logic [1:0] pc_src, alu_src_b, mem_to_reg;
  logic [2:0] alu_op, reg_dst;
  logic [4:0] state;
  logic [20:0] dut_out;
  int n_chk = 0, n_fail = 0, rw_cnt, mem_cnt, cyc_cnt;
  int exp_q[$];
  bit rdy_q[$];
  int op_t[13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
  int fn_t[13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 0, 0, 0, 0, 0, 0, 0};

  mc_control_fsm #(.STATE_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .bad_op(bad_op), .state(state)
  );

  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  assign dut_out = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, alu_src_a,
                    alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, bad_op};

  // Output table straight from the state descriptions.
  // Field order: req we iord irw pcw pcwc pcsrc srca srcb aluop regdst m2r rw bad
  function automatic logic [20:0] exp_out(int s);
    case (s)
      1:  return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      2:  return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      3:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      4:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b010, 3'b000, 2'b00, 1'b0, 1'b0};
      5:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 3'b001, 2'b00, 1'b1, 1'b0};
      6:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      7:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00, 1'b1, 1'b0};
      8:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      9:  return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      10: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000, 2'b01, 1'b1, 1'b0};
      11: return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      12: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 3'b001, 3'b000, 2'b00, 1'b0, 1'b0};
      13: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      14: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 3'b000, 3'b010, 2'b10, 1'b1, 1'b0};
      15: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0};
      16: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00, 1'b0, 1'b1};
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input bit r);
    exp_q.push_back(s);
    rdy_q.push_back(r);
  endtask

  // Instruction-level model: trace = fetch (with waits), decode, then class-specific steps.
  task automatic build(input int k, input int wf, input int wm);
    exp_q.delete();
    rdy_q.delete();
    repeat (wf) push(1, 1'b0);
    push(1, 1'b1);
    push(2, 1'($urandom));
    push(3, 1'($urandom));
    if (k <= 4) begin push(4, 1'($urandom)); push(5, 1'($urandom)); end
    else if (k == 5) push(15, 1'($urandom));
    else if (k == 6) begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
    else if (k == 7 || k == 8) begin
      push(8, 1'($urandom));
      repeat (wm) push(k == 7 ? 9 : 11, 1'b0);
      push(k == 7 ? 9 : 11, 1'b1);
      if (k == 7) push(10, 1'($urandom));
    end
    else if (k == 9) push(12, 1'($urandom));
    else if (k == 10) push(13, 1'($urandom));
    else if (k == 11) push(14, 1'($urandom));
    else repeat (12) push(16, 1'($urandom));
    opcode = 6'(op_t[k]);
    funct  = (op_t[k] == 0) ? 6'(fn_t[k]) : 6'($urandom);
  endtask

  // Called at #1 after an edge; checks then advances one cycle per trace entry.
  task automatic run(input int n);
    rw_cnt = 0; mem_cnt = 0; cyc_cnt = 0;
    for (int i = 0; i < exp_q.size() && (n < 0 || i < n); i++) begin
      chk("state", 32'(state), 32'(exp_q[i]));
      chk("outputs", 32'(dut_out), 32'(exp_out(exp_q[i])));
      rw_cnt  += int'(reg_write);
      mem_cnt += int'(mem_req && iord);
      cyc_cnt++;
      mem_ready = rdy_q[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_check(input string name);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_state"}, 32'(state), 0);
    chk({name, "_outputs"}, 32'(dut_out), 0);
    @(posedge clk); #1;
    chk({name, "_hold"}, 32'(state), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk({name, "_release"}, 32'(state), 1);
  endtask

  initial begin
    #3;
    chk("reset_state", 32'(state), 0);
    chk("reset_outputs", 32'(dut_out), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_fetch", 32'(state), 1);
    // R-type add, zero wait
    build(0, 0, 0);
    chk("add_trace_len", 32'(exp_q.size()), 5);
    chk("add_trace_last", 32'(exp_q[4]), 5);
    run(-1);
    chk("add_rw_cycles", 32'(rw_cnt), 1);
    chk("add_next_fetch", 32'(state), 1);
    // lw with three wait cycles in MRD
    build(7, 0, 3);
    run(-1);
    chk("lw_mrd_cycles", 32'(mem_cnt), 4);
    chk("lw_total", 32'(cyc_cnt), 9);
    // jal, beq, jr
    build(11, 0, 0);
    run(-1);
    chk("jal_cycles", 32'(cyc_cnt), 4);
    build(9, 0, 0);
    run(-1);
    chk("beq_cycles", 32'(cyc_cnt), 4);
    build(5, 0, 0);
    run(-1);
    chk("jr_cycles", 32'(cyc_cnt), 4);
    // sw with a fetch wait and write waits
    build(8, 2, 2);
    run(-1);
    chk("sw_cycles", 32'(cyc_cnt), 9);
    // Reset in the middle of a lw memory read
    build(7, 0, 5);
    run(6);
    chk("mid_mrd_req", 32'(mem_req), 1);
    reset_check("rst_mrd");
    // Illegal opcode then illegal funct
    build(12, 1, 0);
    run(-1);
    chk("trap_bad_op", 32'(bad_op), 1);
    reset_check("rst_trap");
    build(12, 0, 0);
    opcode = 6'h00;
    funct  = 6'h07;
    run(-1);
    chk("trap_funct", 32'(state), 16);
    reset_check("rst_trap2");
    // Random legal instruction stream with random wait states
    repeat (300) begin
      build(int'($urandom_range(0, 11)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run(-1);
    end
    build(int'($urandom_range(0, 11)) == 0 ? 12 : 12, 0, 0);
    opcode = 6'h3F;
    run(-1);
    reset_check("rst_final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
